// File: rtl/barcode_tx_mimic.sv
// ---------------------------------------------------------------------------
// barcode_tx_mimic
//   Bench-side transmitter that serialises an N_BITS station ID onto a single
//   barcode wire (BC). A frame is one calibration start cell followed by
//   N_BITS data cells, MSB first. Each cell lasts P clocks: BC is low for L
//   clocks, then high for the remaining P-L clocks.
//     start cell : L = P/2
//     data bit 1 : L = P/4
//     data bit 0 : L = P/2 + P/4
//   P is the period latched when send is accepted. A latched period below 8
//   is treated as 8.
//
// Ports
//   clk        : system clock
//   rst        : synchronous, active-high reset (aborts any frame in flight)
//   period     : cell length in clocks, sampled when send is accepted
//   send       : 1-cycle frame request, ignored while a frame is in flight
//   station_ID : ID to transmit, sampled when send is accepted
//   BC_done    : set when a frame completes, cleared by the next accepted send
//   BC         : registered barcode line, idles high
// ---------------------------------------------------------------------------
module barcode_tx_mimic #(
  parameter int N_BITS   = 8,
  parameter int PERIOD_W = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] period,
  input  logic                send,
  input  logic [N_BITS-1:0]   station_ID,
  output logic                BC_done,
  output logic                BC
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;

  localparam logic [PERIOD_W-1:0] MIN_PER  = PERIOD_W'(8);
  localparam logic [3:0]          LAST_BIT = 4'(N_BITS - 1);

  logic [1:0]          r_state;
  logic [PERIOD_W-1:0] r_cnt;    // clocks elapsed in the current cell
  logic [PERIOD_W-1:0] r_per;    // latched, clamped cell length
  logic [N_BITS-1:0]   r_sh;     // latched ID; MSB is the bit being sent
  logic [3:0]          r_bit;    // data cell index within the frame
  logic                r_bc;
  logic                r_done;

  logic [PERIOD_W-1:0] w_per_in;
  logic [PERIOD_W-1:0] w_p4;
  logic [PERIOD_W-1:0] w_p2;
  logic [PERIOD_W-1:0] w_p34;
  logic [PERIOD_W-1:0] w_low;
  logic [PERIOD_W-1:0] w_cnt_nxt;
  logic                w_cell_end;
  logic                w_last;

  assign w_per_in   = (period < MIN_PER) ? MIN_PER : period;
  assign w_p4       = r_per >> 2;
  assign w_p2       = r_per >> 1;
  assign w_p34      = w_p2 + w_p4;
  assign w_low      = (r_state == S_START) ? w_p2 :
                      (r_sh[N_BITS-1]      ? w_p4 : w_p34);
  assign w_cnt_nxt  = r_cnt + 1'b1;
  assign w_cell_end = (w_cnt_nxt == r_per);
  assign w_last     = (r_bit == LAST_BIT);

  // The BC value registered on an edge belongs to cell position w_cnt_nxt,
  // so a cell reads low while its position is below w_low. A new cell starts
  // with BC falling on the same edge that resets the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_per   <= '0;
      r_sh    <= '0;
      r_bit   <= '0;
      r_bc    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bc <= 1'b1;
          if (send) begin
            r_per   <= w_per_in;
            r_sh    <= station_ID;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_bc    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_cell_end) begin
            r_cnt   <= '0;
            r_bc    <= 1'b0;
            r_state <= S_DATA;
          end else begin
            r_cnt <= w_cnt_nxt;
            r_bc  <= (w_cnt_nxt >= w_low);
          end
        end
        S_DATA: begin
          if (w_cell_end) begin
            r_cnt <= '0;
            if (w_last) begin
              // send on this edge is ignored: the state is not yet IDLE
              r_bc    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_bc  <= 1'b0;
              r_bit <= r_bit + 1'b1;
              r_sh  <= {r_sh[N_BITS-2:0], 1'b0};
            end
          end else begin
            r_cnt <= w_cnt_nxt;
            r_bc  <= (w_cnt_nxt >= w_low);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_bc    <= 1'b1;
        end
      endcase
    end
  end

  assign BC      = r_bc;
  assign BC_done = r_done;

endmodule

// File: tb/tb_barcode_tx_mimic.sv
// ---------------------------------------------------------------------------
// tb_barcode_tx_mimic
//   Randomised frames checked cycle by cycle against a waveform model that
//   derives BC from (cycle offset / P, cycle offset % P), plus decoded-ID and
//   low-width checks, reset abort, mid-frame and late send requests.
// ---------------------------------------------------------------------------
module tb_barcode_tx_mimic;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] period;
  logic        send;
  logic [7:0]  station_ID;
  logic        BC_done;
  logic        BC;

  int n_tests = 0;
  int n_fail  = 0;
  int lows[9];

  barcode_tx_mimic dut (
    .clk        (clk),
    .rst        (rst),
    .period     (period),
    .send       (send),
    .station_ID (station_ID),
    .BC_done    (BC_done),
    .BC         (BC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Expected BC at offset t (t=0 is the cycle right after the accept edge).
  function automatic logic exp_bc(input int t, input int p, input logic [7:0] id);
    int c, pos, l;
    if (t >= 9 * p) return 1'b1;
    c   = t / p;
    pos = t % p;
    if (c == 0)            l = p / 2;
    else if (id[8 - c])    l = p / 4;
    else                   l = p / 2 + p / 4;
    return (pos >= l);
  endfunction

  // abort_t >= 0 pulses rst at that offset and stops the frame there.
  task automatic run_frame(input int pin, input logic [7:0] id, input bit mid_send,
                           input bit late_send, input int abort_t);
    int p, lowcnt, c, pos;
    logic [7:0] dec;
    p = (pin < 8) ? 8 : pin;
    lowcnt = 0;
    dec = '0;
    @(negedge clk);
    period = 22'(pin); station_ID = id; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    for (int t = 0; t <= 9 * p; t++) begin
      if (t > 0) @(negedge clk);
      chk("bc", {31'd0, BC}, {31'd0, exp_bc(t, p, id)});
      chk("done", {31'd0, BC_done}, (t >= 9 * p) ? 32'd1 : 32'd0);
      if (t < 9 * p) begin
        c = t / p; pos = t % p;
        if (BC == 1'b0) lowcnt++;
        if (pos == p - 1) begin
          lows[c] = lowcnt;
          if (c > 0) dec = {dec[6:0], (lowcnt < p / 2)};
          lowcnt = 0;
        end
      end
      // Inputs wander mid-frame; the latched values must win.
      period = 22'($urandom); station_ID = 8'($urandom);
      send = 1'b0;
      if (mid_send && (t == p + 3 || t == 5 * p)) send = 1'b1;
      if (late_send && t == 9 * p - 1) send = 1'b1;
      if (abort_t >= 0 && t == abort_t) begin
        send = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_bc", {31'd0, BC}, 32'd1);
        chk("abort_done", {31'd0, BC_done}, 32'd0);
        for (int k = 0; k < 3 * p; k++) begin
          @(negedge clk);
          chk("abort_idle", {30'd0, BC_done, BC}, 32'd1);
        end
        return;
      end
    end
    chk("decode", {24'd0, dec}, {24'd0, id});
    send = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_after", {30'd0, BC_done, BC}, 32'd3);
    end
  endtask

  initial begin
    int exp_w[9];
    rst = 1'b1; send = 1'b0; period = '0; station_ID = '0;
    repeat (3) @(negedge clk);
    chk("rst_bc", {31'd0, BC}, 32'd1);
    chk("rst_done", {31'd0, BC_done}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("idle_bc", {31'd0, BC}, 32'd1);
    end

    // Full-size frame with explicit low widths.
    run_frame(32'h1000, 8'hA5, 1'b0, 1'b0, -1);
    exp_w = '{2048, 1024, 3072, 1024, 3072, 3072, 1024, 3072, 1024};
    for (int i = 0; i < 9; i++) chk("a5_width", lows[i], exp_w[i]);

    run_frame(64, 8'h01, 1'b0, 1'b0, -1);
    run_frame(3, 8'hFF, 1'b0, 1'b0, -1);
    for (int i = 0; i < 9; i++) chk("clamp_width", lows[i], (i == 0) ? 4 : 2);
    run_frame(0, 8'h00, 1'b0, 1'b0, -1);
    run_frame(40, 8'h5A, 1'b1, 1'b0, -1);   // ignored mid-frame sends
    run_frame(17, 8'hC3, 1'b0, 1'b1, -1);   // send on the completion edge
    run_frame(32, 8'h96, 1'b0, 1'b0, 5 * 32 + 7); // reset during bit 3
    run_frame(32, 8'h3C, 1'b0, 1'b0, -1);   // fresh frame after abort

    for (int n = 0; n < 16; n++)
      run_frame($urandom_range(1, 48), 8'($urandom), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
